// File: rtl/wb_rr_interconnect.sv
// Shared-bus Wishbone interconnect with N masters and M slaves. Round-robin arbitration locks
// the bus for a whole CYC. Address decode uses per-slave masks. Unmapped addresses and slave
// timeouts raise a bus error.
module wb_rr_interconnect #(
   parameter int N_M = 4,
   parameter int N_S = 6,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int DEC_W = 3,
   parameter logic [N_S*DEC_W-1:0] S_ADDR = '0,
   parameter logic [N_S*DEC_W-1:0] S_MASK = '1,
   parameter int TIMEOUT = 255
) (
   input  logic                      sys_clk,
   input  logic                      sys_rst,
   input  logic [N_M*ADDR_W-1:0]     m_adr_i,
   input  logic [N_M*DATA_W-1:0]     m_dat_i,
   input  logic [N_M*DATA_W/8-1:0]   m_sel_i,
   input  logic [N_M*3-1:0]          m_cti_i,
   input  logic [N_M-1:0]            m_we_i,
   input  logic [N_M-1:0]            m_cyc_i,
   input  logic [N_M-1:0]            m_stb_i,
   output logic [DATA_W-1:0]         m_dat_o,
   output logic [N_M-1:0]            m_ack_o,
   output logic [N_M-1:0]            m_err_o,
   output logic [ADDR_W-1:0]         s_adr_o,
   output logic [DATA_W-1:0]         s_dat_o,
   output logic [DATA_W/8-1:0]       s_sel_o,
   output logic [2:0]                s_cti_o,
   output logic                      s_we_o,
   output logic [N_S-1:0]            s_cyc_o,
   output logic [N_S-1:0]            s_stb_o,
   input  logic [N_S*DATA_W-1:0]     s_dat_i,
   input  logic [N_S-1:0]            s_ack_i,
   input  logic [N_S-1:0]            s_err_i
);

   localparam int SEL_W = DATA_W / 8;
   localparam int LW = (N_M > 1) ? $clog2(N_M) : 1;
   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic {IDLE, GRANT} state_t;

   state_t          state, state_nx;
   logic [N_M-1:0]  grant, grant_nx, pick;
   logic [LW-1:0]   last, last_nx, cand, g_idx;
   logic [TW-1:0]   tmo_cnt, tmo_nx;
   logic            err_r, err_nx;
   logic            found, found_s, granted, bus_cyc, bus_stb;
   logic            any_hit, t_ack, t_err, tmo_err;
   logic [DEC_W-1:0] dec;
   logic [N_S-1:0]  hit, s_sel;
   logic [DATA_W-1:0] rdat;

   // Rotating-priority search: start one past the last served master and wrap.
   always_comb begin
      pick = '0;
      found = 1'b0;
      cand = '0;
      for (int k = 1; k <= N_M; k++) begin
         cand = LW'((int'(last) + k) % N_M);
         if (!found && m_cyc_i[cand]) begin
            pick[cand] = 1'b1;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      g_idx = '0;
      s_adr_o = '0;
      s_dat_o = '0;
      s_sel_o = '0;
      s_cti_o = '0;
      s_we_o = 1'b0;
      for (int j = 0; j < N_M; j++) begin
         if (grant[j]) begin
            g_idx = LW'(j);
            s_adr_o = m_adr_i[j*ADDR_W +: ADDR_W];
            s_dat_o = m_dat_i[j*DATA_W +: DATA_W];
            s_sel_o = m_sel_i[j*SEL_W +: SEL_W];
            s_cti_o = m_cti_i[j*3 +: 3];
            s_we_o = m_we_i[j];
         end
      end
   end

   assign granted = (state == GRANT);
   assign bus_cyc = granted & |(m_cyc_i & grant);
   assign bus_stb = granted & |(m_stb_i & grant);
   // The top address bit is the cache-bypass shadow and takes no part in decode.
   assign dec = s_adr_o[ADDR_W-2 -: DEC_W];

   always_comb begin
      hit = '0;
      s_sel = '0;
      found_s = 1'b0;
      rdat = '0;
      for (int i = 0; i < N_S; i++) begin
         hit[i] = ((dec ^ S_ADDR[i*DEC_W +: DEC_W]) & S_MASK[i*DEC_W +: DEC_W]) == '0;
         if (!found_s && hit[i]) begin
            s_sel[i] = 1'b1;
            found_s = 1'b1;
            rdat = s_dat_i[i*DATA_W +: DATA_W];
         end
      end
   end

   assign any_hit = |hit;
   assign t_ack = bus_cyc & |(s_ack_i & s_sel);
   assign t_err = bus_cyc & |(s_err_i & s_sel);
   // A slave ack in the timeout cycle takes precedence over the timeout error.
   assign tmo_err = (TIMEOUT != 0) && bus_stb && bus_cyc && any_hit && !t_ack && !t_err
                    && (tmo_cnt == TW'(TIMEOUT));

   assign s_cyc_o = bus_cyc ? s_sel : '0;
   assign s_stb_o = (bus_cyc & bus_stb) ? s_sel : '0;
   assign m_dat_o = (granted & any_hit) ? rdat : '0;
   assign m_ack_o = t_ack ? grant : '0;
   assign m_err_o = (t_err | err_r | tmo_err) ? grant : '0;

   // Arbitration, bus lock, miss-error pulse and timeout counting.
   always_comb begin
      state_nx = state;
      grant_nx = grant;
      last_nx = last;
      err_nx = 1'b0;
      tmo_nx = '0;
      case (state)
         IDLE: begin
            if (|m_cyc_i) begin
               grant_nx = pick;
               state_nx = GRANT;
            end
         end
         GRANT: begin
            if (!bus_cyc) begin
               last_nx = g_idx;
               grant_nx = '0;
               state_nx = IDLE;
            end else begin
               err_nx = bus_stb & !any_hit & !err_r;
               if (bus_stb && any_hit && !t_ack && !t_err && (tmo_cnt != TW'(TIMEOUT)))
                  tmo_nx = tmo_cnt + TW'(1);
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state <= IDLE;
         grant <= '0;
         last <= LW'(N_M - 1);
         tmo_cnt <= '0;
         err_r <= 1'b0;
      end else begin
         state <= state_nx;
         grant <= grant_nx;
         last <= last_nx;
         tmo_cnt <= tmo_nx;
         err_r <= err_nx;
      end
   end

endmodule

// File: tb/tb_wb_rr_interconnect.sv
// Directed bench for wb_rr_interconnect. It covers decode, the shadow bit, round-robin order,
// unmapped-address errors, timeout behaviour and reset in the middle of a transfer.
module tb_wb_rr_interconnect;

   localparam logic [17:0] S_ADDR_P = {3'b110, 3'b101, 3'b011, 3'b010, 3'b001, 3'b000};

   logic          sys_clk = 1'b0;
   logic          sys_rst;
   logic [127:0]  m_adr_i;
   logic [127:0]  m_dat_i;
   logic [15:0]   m_sel_i;
   logic [11:0]   m_cti_i;
   logic [3:0]    m_we_i;
   logic [3:0]    m_cyc_i;
   logic [3:0]    m_stb_i;
   logic [31:0]   m_dat_o;
   logic [3:0]    m_ack_o;
   logic [3:0]    m_err_o;
   logic [31:0]   s_adr_o;
   logic [31:0]   s_dat_o;
   logic [3:0]    s_sel_o;
   logic [2:0]    s_cti_o;
   logic          s_we_o;
   logic [5:0]    s_cyc_o;
   logic [5:0]    s_stb_o;
   logic [191:0]  s_dat_i;
   logic [5:0]    s_ack_i;
   logic [5:0]    s_err_i;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0]        cyc;
      logic [3:0]        stb;
      logic [3:0][31:0]  adr;
      logic [5:0]        ack;
      logic [5:0]        err;
      logic [5:0]        exp_scyc;
      logic [5:0]        exp_sstb;
      logic [3:0]        exp_ack;
      logic [3:0]        exp_err;
      logic [31:0]       exp_dat;
   } vec_t;

   vec_t tbl[$];
   vec_t v;

   wb_rr_interconnect #(
      .N_M(4), .N_S(6), .ADDR_W(32), .DATA_W(32), .DEC_W(3),
      .S_ADDR(S_ADDR_P), .S_MASK({6{3'b111}}), .TIMEOUT(8)
   ) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst),
      .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_cti_i(m_cti_i),
      .m_we_i(m_we_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
      .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_cti_o(s_cti_o),
      .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
      .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i)
   );

   always #5 sys_clk = ~sys_clk;

   // Fixed per-master addresses: M1 is unmapped, M2 hits slave 1, M3 hits slave 4.
   function automatic vec_t mk(input logic [3:0] cyc, input logic [3:0] stb,
                               input logic [31:0] a0, input logic [5:0] ack,
                               input logic [5:0] err, input logic [5:0] esc,
                               input logic [5:0] esb, input logic [3:0] eack,
                               input logic [3:0] eerr, input logic [31:0] edat);
      vec_t r;
      r.cyc = cyc; r.stb = stb;
      r.adr = {32'h5000_0000, 32'h1000_0000, 32'h4000_0000, a0};
      r.ack = ack; r.err = err;
      r.exp_scyc = esc; r.exp_sstb = esb; r.exp_ack = eack; r.exp_err = eerr;
      r.exp_dat = edat;
      return r;
   endfunction

   task automatic applyStimulus(input vec_t s);
      m_cyc_i = s.cyc;
      m_stb_i = s.stb;
      m_adr_i = s.adr;
      s_ack_i = s.ack;
      s_err_i = s.err;
   endtask

   task automatic checkOne(input string tag, input string what,
                           input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s.%s got %h expected %h", tag, what, got, exp);
      end
   endtask

   task automatic checkOutput(input vec_t s, input string tag);
      checkOne(tag, "s_cyc", 32'(s_cyc_o), 32'(s.exp_scyc));
      checkOne(tag, "s_stb", 32'(s_stb_o), 32'(s.exp_sstb));
      checkOne(tag, "m_ack", 32'(m_ack_o), 32'(s.exp_ack));
      checkOne(tag, "m_err", 32'(m_err_o), 32'(s.exp_err));
      checkOne(tag, "m_dat", m_dat_o, s.exp_dat);
   endtask

   initial begin
      for (int i = 0; i < 6; i++) s_dat_i[i*32 +: 32] = 32'hD000_0000 | 32'(i);
      s_dat_i[5*32 +: 32] = 32'hDEAD_BEEF;
      for (int j = 0; j < 4; j++) begin
         m_dat_i[j*32 +: 32] = 32'h1111_0000 | 32'(j);
         m_sel_i[j*4 +: 4] = 4'(1 << j);
         m_cti_i[j*3 +: 3] = 3'(j);
         m_we_i[j] = j[0];
      end

      //         cyc     stb     adr0          ack       err       scyc      sstb      ack     err     dat
      tbl.push_back(mk(4'h0, 4'h0, 32'h6000_0004, 6'h00, 6'h00, 6'h00, 6'h00, 4'h0, 4'h0, 32'h0));
      tbl.push_back(mk(4'h1, 4'h1, 32'h6000_0004, 6'h00, 6'h00, 6'h00, 6'h00, 4'h0, 4'h0, 32'h0));
      tbl.push_back(mk(4'h1, 4'h1, 32'h6000_0004, 6'h00, 6'h00, 6'h20, 6'h20, 4'h0, 4'h0, 32'hDEAD_BEEF));
      tbl.push_back(mk(4'h1, 4'h1, 32'h6000_0004, 6'h20, 6'h00, 6'h20, 6'h20, 4'h1, 4'h0, 32'hDEAD_BEEF));
      tbl.push_back(mk(4'h0, 4'h0, 32'h6000_0004, 6'h00, 6'h00, 6'h00, 6'h00, 4'h0, 4'h0, 32'hDEAD_BEEF));
      tbl.push_back(mk(4'h1, 4'h1, 32'hE000_0004, 6'h00, 6'h00, 6'h00, 6'h00, 4'h0, 4'h0, 32'h0));
      tbl.push_back(mk(4'h1, 4'h1, 32'hE000_0004, 6'h20, 6'h00, 6'h20, 6'h20, 4'h1, 4'h0, 32'hDEAD_BEEF));
      tbl.push_back(mk(4'h0, 4'h0, 32'hE000_0004, 6'h00, 6'h00, 6'h00, 6'h00, 4'h0, 4'h0, 32'hDEAD_BEEF));
      tbl.push_back(mk(4'h2, 4'h2, 32'h6000_0004, 6'h00, 6'h00, 6'h00, 6'h00, 4'h0, 4'h0, 32'h0));
      tbl.push_back(mk(4'h2, 4'h2, 32'h6000_0004, 6'h00, 6'h00, 6'h00, 6'h00, 4'h0, 4'h0, 32'h0));
      tbl.push_back(mk(4'h2, 4'h2, 32'h6000_0004, 6'h00, 6'h00, 6'h00, 6'h00, 4'h0, 4'h2, 32'h0));
      tbl.push_back(mk(4'h2, 4'h0, 32'h6000_0004, 6'h00, 6'h00, 6'h00, 6'h00, 4'h0, 4'h0, 32'h0));
      tbl.push_back(mk(4'h0, 4'h0, 32'h6000_0004, 6'h00, 6'h00, 6'h00, 6'h00, 4'h0, 4'h0, 32'h0));
      tbl.push_back(mk(4'h4, 4'h4, 32'h6000_0004, 6'h00, 6'h00, 6'h00, 6'h00, 4'h0, 4'h0, 32'h0));
      tbl.push_back(mk(4'h4, 4'h4, 32'h6000_0004, 6'h02, 6'h00, 6'h02, 6'h02, 4'h4, 4'h0, 32'hD000_0001));
      tbl.push_back(mk(4'h0, 4'h0, 32'h6000_0004, 6'h00, 6'h00, 6'h00, 6'h00, 4'h0, 4'h0, 32'hD000_0001));
      tbl.push_back(mk(4'h8, 4'h8, 32'h6000_0004, 6'h00, 6'h00, 6'h00, 6'h00, 4'h0, 4'h0, 32'h0));
      tbl.push_back(mk(4'h8, 4'h8, 32'h6000_0004, 6'h00, 6'h10, 6'h10, 6'h10, 4'h0, 4'h8, 32'hD000_0004));
      tbl.push_back(mk(4'h0, 4'h0, 32'h6000_0004, 6'h00, 6'h00, 6'h00, 6'h00, 4'h0, 4'h0, 32'hD000_0004));

      sys_rst = 1'b1;
      applyStimulus(tbl[0]);
      repeat (3) @(posedge sys_clk);
      @(negedge sys_clk);
      #1 checkOutput(tbl[0], "reset");
      sys_rst = 1'b0;

      foreach (tbl[i]) begin
         @(negedge sys_clk);
         applyStimulus(tbl[i]);
         #1 checkOutput(tbl[i], $sformatf("vec%0d", i));
      end

      // All four masters request continuously and each drops cyc after one ack.
      for (int n = 0; n < 5; n++) begin
         int g;
         g = n % 4;
         @(negedge sys_clk);
         v = mk(4'hF, 4'hF, 32'h0, 6'h01, 6'h00, 6'h00, 6'h00, 4'h0, 4'h0, 32'h0);
         v.adr = '0;
         applyStimulus(v);
         #1 checkOutput(v, $sformatf("rr%0d_idle", n));
         @(negedge sys_clk);
         v.exp_scyc = 6'h01; v.exp_sstb = 6'h01; v.exp_ack = 4'(1 << g);
         v.exp_dat = 32'hD000_0000;
         applyStimulus(v);
         #1 checkOutput(v, $sformatf("rr%0d_grant", n));
         @(negedge sys_clk);
         v.cyc = 4'hF & ~4'(1 << g); v.stb = v.cyc;
         v.exp_scyc = 6'h00; v.exp_sstb = 6'h00; v.exp_ack = 4'h0;
         applyStimulus(v);
         #1 checkOutput(v, $sformatf("rr%0d_drop", n));
      end

      // Timeout: a silent slave errors on the 9th strobe cycle; an ack at count 8 wins.
      @(negedge sys_clk);
      v = mk(4'h2, 4'h2, 32'h0, 6'h00, 6'h00, 6'h00, 6'h00, 4'h0, 4'h0, 32'h0);
      v.adr = {4{32'h0000_0010}};
      applyStimulus(v);
      #1 checkOutput(v, "tmo_idle");
      for (int k = 1; k <= 19; k++) begin
         @(negedge sys_clk);
         v.exp_scyc = 6'h01; v.exp_sstb = 6'h01; v.exp_dat = 32'hD000_0000;
         v.ack = (k == 18) ? 6'h01 : 6'h00;
         v.exp_ack = (k == 18) ? 4'h2 : 4'h0;
         v.exp_err = (k == 9) ? 4'h2 : 4'h0;
         applyStimulus(v);
         #1 checkOutput(v, $sformatf("tmo%0d", k));
         if (k == 1) begin
            checkOne("bcast", "adr", s_adr_o, 32'h0000_0010);
            checkOne("bcast", "dat", s_dat_o, 32'h1111_0001);
            checkOne("bcast", "sel", 32'(s_sel_o), 32'h2);
            checkOne("bcast", "cti", 32'(s_cti_o), 32'h1);
            checkOne("bcast", "we", 32'(s_we_o), 32'h1);
         end
      end

      // Reset while M1 still holds the bus.
      @(negedge sys_clk);
      sys_rst = 1'b1;
      v.ack = 6'h01;
      applyStimulus(v);
      @(negedge sys_clk);
      v.exp_scyc = 6'h00; v.exp_sstb = 6'h00; v.exp_ack = 4'h0; v.exp_err = 4'h0;
      v.exp_dat = 32'h0;
      #1 checkOutput(v, "rst_mid");
      @(negedge sys_clk);
      sys_rst = 1'b0;
      #1 checkOutput(v, "rst_idle");
      @(negedge sys_clk);
      v.exp_scyc = 6'h01; v.exp_sstb = 6'h01; v.exp_ack = 4'h2; v.exp_dat = 32'hD000_0000;
      #1 checkOutput(v, "rst_regrant");
      @(negedge sys_clk);
      applyStimulus(tbl[0]);
      repeat (2) @(negedge sys_clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
